hazard_ctrl_unit: RTL
=====================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-specifier width.
REQ-002 SHALL have parameter MC_LAT, default 4, legal range 1..16; execute latency of a multi-cycle (SAD/MUL) op in cycles.
REQ-003 SHALL have parameter LU_STALLS, default 1, legal values 1 or 2; load-use stall depth (1 = MEM->EX forwarding present, 2 = absent).
REQ-004 SHALL have parameter BRANCH_IN_EX, default 1; 1 = branch resolved in EX, 0 = resolved in ID.
REQ-005 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-006 SHALL have a single clock and an asynchronous, active-low reset; no other clock or reset exists.
REQ-007 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- id_rs, id_rt  in  REG_AW  ID source specifiers
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  jump in ID
- ex_memread  in  1  load in EX
- ex_rd  in  REG_AW  EX destination
- mem_memread  in  1  load in MEM
- mem_rd  in  REG_AW  MEM destination
- ex_mc_start  in  1  multi-cycle op in EX
- br_taken  in  1  taken branch resolved this cycle
- pc_write_en  out  1  PC update enable
- ifid_write_en  out  1  IF/ID write enable
- idex_write_en  out  1  ID/EX write enable
- idex_bubble  out  1  zero ID/EX control
- exmem_bubble  out  1  zero EX/MEM control
- flush_ifid  out  1  flush IF/ID
- flush_idex  out  1  flush ID/EX
- stall_cycles  out  CNT_W  stall-cycle count
- flush_events  out  CNT_W  flush-event count

Function
REQ-008 Default outputs: all write enables 1; bubbles and flushes 0.
REQ-009 Load-use hazard SHALL be: ex_memread=1, ex_rd!=0, and (ex_rd==id_rs or (id_uses_rt=1 and ex_rd==id_rt)); when LU_STALLS=2, the same test applied to mem_memread/mem_rd also counts.
REQ-010 On load-use hazard, same cycle: pc_write_en=0, ifid_write_en=0, idex_bubble=1; purely combinational, no added latency.
REQ-011 FSM states RUN, MC_WAIT; 4-bit down-counter mc_cnt.
REQ-012 In RUN with ex_mc_start=1 and MC_LAT>1: freeze (pc_write_en=0, ifid_write_en=0, idex_write_en=0, exmem_bubble=1) that cycle; if MC_LAT>2, next state MC_WAIT with mc_cnt=MC_LAT-3.
REQ-013 In MC_WAIT: freeze every cycle; mc_cnt==0 -> RUN, else decrement; ex_mc_start ignored. Total frozen cycles per op = MC_LAT-1.
REQ-014 MC_LAT=1: ex_mc_start SHALL have no effect.
REQ-015 br_taken=1 (not in freeze): flush_ifid=1, flush_idex=BRANCH_IN_EX, pc_write_en=1, ifid_write_en=1, idex_bubble=0.
REQ-016 br_taken SHALL be ignored while freeze is asserted.
REQ-017 id_jump=1 with no higher-priority condition: flush_ifid=1, pc_write_en=1.
REQ-018 Priority, highest first: freeze, br_taken, load-use, id_jump.
REQ-019 id_rs/id_rt of 0 SHALL never match.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state RUN, mc_cnt=0, counters 0; outputs take REQ-008 defaults while reset is held.
REQ-021 Reset asserted mid-MC_WAIT SHALL abort the freeze immediately; first cycle after release is RUN.

Configuration
REQ-022 Macro HAZARD_PERF_CNT_EN defined: stall_cycles increments on each cycle with pc_write_en=0; flush_events increments on each cycle with flush_ifid=1; both saturate at all-ones.
REQ-023 Macro undefined: stall_cycles and flush_events SHALL be constant 0 with no counter flops; all other behaviour identical.

Verification
REQ-024 ex_memread=1, ex_rd=8, id_rs=8 -> same cycle pc_write_en=0, ifid_write_en=0, idex_bubble=1; next cycle (load in MEM, LU_STALLS=1) no stall.
REQ-025 LU_STALLS=2, load rd=9 consumed by id_rt=9, id_uses_rt=1 -> exactly 2 stall cycles.
REQ-026 MC_LAT=4, ex_mc_start held 1 -> exactly 3 freeze cycles, exmem_bubble=1 each, RUN afterwards; MC_LAT=1 -> none.
REQ-027 BRANCH_IN_EX=1, br_taken pulse -> flush_ifid=1, flush_idex=1 one cycle; with BRANCH_IN_EX=0 flush_idex=0; br_taken during freeze -> no flush.
REQ-028 rst_n low at 2nd MC_WAIT cycle -> outputs default immediately; perf counters (macro defined) read 0; id_rs=0 vs ex_rd=0 load -> no stall.

Source files
------------

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller bundle: ID/EX/MEM hazard sources in, stall/flush controls and perf counts out.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              id_jump;
  logic              ex_memread;
  logic [REG_AW-1:0] ex_rd;
  logic              mem_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              ex_mc_start;
  logic              br_taken;

  logic              pc_write_en;
  logic              ifid_write_en;
  logic              idex_write_en;
  logic              idex_bubble;
  logic              exmem_bubble;
  logic              flush_ifid;
  logic              flush_idex;
  logic [CNT_W-1:0]  stall_cycles;
  logic [CNT_W-1:0]  flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rd,
           mem_memread, mem_rd, ex_mc_start, br_taken,
    input  pc_write_en, ifid_write_en, idex_write_en, idex_bubble,
           exmem_bubble, flush_ifid, flush_idex, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rd,
           mem_memread, mem_rd, ex_mc_start, br_taken,
    output pc_write_en, ifid_write_en, idex_write_en, idex_bubble,
           exmem_bubble, flush_ifid, flush_idex, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall, multi-cycle freeze, branch/jump flush; controls are combinational (0 cycles), no backpressure.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush counters; otherwise they read constant 0.
module hazard_ctrl_unit #(
  parameter int REG_AW       = 5,
  parameter int MC_LAT       = 4,
  parameter int LU_STALLS    = 1,
  parameter int BRANCH_IN_EX = 1,
  parameter int CNT_W        = 16
) (
  input logic               clk,
  input logic               rst_n,
  hazard_ctrl_unit_if.slave hz
);

  localparam logic [REG_AW-1:0] REG_ZERO  = '0;
  localparam logic [3:0]        MC_INIT   = (MC_LAT > 2) ? 4'(MC_LAT - 3) : 4'd0;
  localparam bit                MC_ACTIVE = (MC_LAT > 1);
  localparam bit                MC_WAITS  = (MC_LAT > 2);
  localparam bit                LU_MEM    = (LU_STALLS == 2);
  localparam bit                BR_EX     = (BRANCH_IN_EX != 0);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] mc_cnt_q, mc_cnt_d;
  logic       freeze;
  logic       lu_hazard;

  logic pc_we, ifid_we, idex_we, idex_bub, exmem_bub, fl_ifid, fl_idex;

  // Register 0 is hard-wired, so neither a zero destination nor a zero source can create a dependency.
  function automatic logic lu_hit(input logic ld, input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                                  input logic uses_rt);
    lu_hit = ld && (rd != REG_ZERO) &&
             (((rs != REG_ZERO) && (rd == rs)) || (uses_rt && (rt != REG_ZERO) && (rd == rt)));
  endfunction

  assign lu_hazard = lu_hit(hz.ex_memread, hz.ex_rd, hz.id_rs, hz.id_rt, hz.id_uses_rt) ||
                     (LU_MEM && lu_hit(hz.mem_memread, hz.mem_rd, hz.id_rs, hz.id_rt, hz.id_uses_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      mc_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
    end
  end

  // The RUN cycle that sees ex_mc_start is the first frozen cycle, so MC_WAIT covers the remaining MC_LAT-2.
  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    freeze   = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.ex_mc_start && MC_ACTIVE) begin
          freeze = 1'b1;
          if (MC_WAITS) begin
            state_d  = MC_WAIT;
            mc_cnt_d = MC_INIT;
          end
        end
      end
      MC_WAIT: begin
        freeze = 1'b1;
        if (mc_cnt_q == 4'd0) state_d = RUN;
        else                  mc_cnt_d = mc_cnt_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    idex_we   = 1'b1;
    idex_bub  = 1'b0;
    exmem_bub = 1'b0;
    fl_ifid   = 1'b0;
    fl_idex   = 1'b0;
    if (!rst_n) begin
      pc_we = 1'b1;
    end else if (freeze) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      idex_we   = 1'b0;
      exmem_bub = 1'b1;
    end else if (hz.br_taken) begin
      fl_ifid = 1'b1;
      fl_idex = BR_EX;
    end else if (lu_hazard) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_bub = 1'b1;
    end else if (hz.id_jump) begin
      fl_ifid = 1'b1;
    end
  end

  assign hz.pc_write_en   = pc_we;
  assign hz.ifid_write_en = ifid_we;
  assign hz.idex_write_en = idex_we;
  assign hz.idex_bubble   = idex_bub;
  assign hz.exmem_bubble  = exmem_bub;
  assign hz.flush_ifid    = fl_ifid;
  assign hz.flush_idex    = fl_idex;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (fl_ifid && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_events = {CNT_W{1'b0}};
`endif

endmodule
